dm_pipe: RTL
============

// Module: dm_pipe
// PURPOSE
//   Parametrised single-port data memory for the CPU MEM stage with valid/ready request,
//   fixed-latency response, byte/half/word stores, sign/zero-extended loads and a
//   self-clearing init sequencer. Sits between the MEM-stage load/store unit and the WB stage.
// PARAMETERS
//   DEPTH   4096  number of 32-bit words; power of two, >=16
//   RD_LAT  1     response latency in cycles after accept; legal values 1 or 2
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   req_valid    in   1   request present
//   req_ready    out  1   block can accept a request this cycle
//   req_we       in   1   1 = store, 0 = load
//   req_size     in   2   00 byte, 01 half, 10 word, 11 reserved
//   req_signed   in   1   load sign-extends when 1; ignored for stores and word loads
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   resp_valid   out  1   one-cycle pulse per accepted request
//   resp_rdata   out  32  formatted load data; 0 for stores and errors
//   resp_err     out  1   request faulted; qualifies resp_valid
//   init_done    out  1   high once the clear sequence has finished
// BEHAVIOUR
// - Reset: all outputs 0; state <= INIT, clr_cnt <= 0; in-flight responses are dropped.
// - FSM: INIT: write 0 to word clr_cnt each cycle, clr_cnt++; after word DEPTH-1 -> RUN
//   (exactly DEPTH cycles). RUN: req_ready=1, init_done=1. Only reset leaves RUN.
// - Accept = req_valid & req_ready; one request per cycle max; no back-pressure on response.
// - Word index = req_addr[log2(DEPTH)+1:2]. Out of range (any req_addr[31:log2(DEPTH)+2] set)
//   or req_size==11 -> err: no write, rdata 0.
// - Store lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0} pair; word -> all four.
//   Write data replicated into the selected lanes; unselected bytes keep old value.
//   Memory updates at the accept edge.
// - Load: byte/half extracted from the same lanes as stores, then sign- (req_signed=1)
//   or zero-extended to 32 bits.
// - Latency: resp_valid, resp_rdata and resp_err appear exactly RD_LAT cycles after
//   accept, one response per accept, in order. RD_LAT=2 adds one output register stage.
// - Store followed by load of the same word in the next cycle returns the new data
//   (write-first); no stall required.
// - Back-to-back accepts give back-to-back responses; resp_valid low in cycles with no
//   matured request; resp_rdata/resp_err are 0 whenever resp_valid=0.
// - Reset asserted mid-INIT or mid-RUN restarts INIT from word 0.
// CONFIGURATION
//   DM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> resp_err=1,
//     no write, rdata 0.
//   Not defined: misaligned low bits ignored (half uses addr[1] only, word ignores
//     addr[1:0]); resp_err raised only for range/reserved-size faults.
// TESTING
//   1. reset 1 cycle, DEPTH=16 -> req_ready=0 for 16 cycles, init_done=1 on cycle 17;
//      all 16 words read back 0.
//   2. sw 0x11223344 @0x0, sb 0xAA @0x1, lw @0x0 -> rdata 0x1122AA44, RD_LAT cycles after
//      the lw accept.
//   3. sh 0x8001 @0x6; lh @0x6 -> 0xFFFF8001; lhu @0x6 -> 0x00008001;
//      lb @0x7 -> 0xFFFFFF80.
//   4. sw 0xDEADBEEF @0x40 then lw @0x40 next cycle -> 0xDEADBEEF;
//      repeat with RD_LAT=2 -> response 2 cycles after accept.
//   5. lw @(DEPTH*4) and req_size=11 -> resp_err=1, rdata 0, memory unchanged;
//      lw @0x2 -> err=1 with DM_ALIGN_CHECK_EN, else data of word 0.
//   6. reset asserted with 2 responses in flight -> resp_valid=0 next cycle, no stale
//      response, INIT restarts at word 0.

Source files
------------

// File: rtl/dm_pipe.sv
// MEM-stage data memory: valid/ready request, fixed-latency response, self-clear on reset.
// Optional feature: define DM_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module dm_pipe #(
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic [AW-1:0]   idx;
    logic            range_err;
    logic            size_err;
    logic            align_err;
    logic            err;
    logic [31:0]     word;
    logic [31:0]     word_sh;
    logic [15:0]     half_sel;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     merged;
    logic [31:0]     ld;

    logic            v1;
    logic [31:0]     d1;
    logic            e1;

    // A request presented in the reset cycle is not taken.
    assign accept    = req_valid & req_ready & ~reset;
    assign idx       = req_addr[AW+1:2];
    assign range_err = |(req_addr >> (AW + 2));
    assign size_err  = (req_size == 2'b11);

`ifdef DM_ALIGN_CHECK_EN
    assign align_err = ((req_size == 2'b01) & req_addr[0]) |
                       ((req_size == 2'b10) & (|req_addr[1:0]));
`else
    assign align_err = 1'b0;
`endif

    assign err      = range_err | size_err | align_err;
    assign word     = mem[idx];
    assign word_sh  = word >> {req_addr[1:0], 3'b000};
    assign half_sel = req_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        be = 4'b0000;
        wd = req_wdata;
        ld = 32'd0;
        unique case (1'b1)
            req_size == 2'b00: begin
                be = 4'b0001 << req_addr[1:0];
                wd = {4{req_wdata[7:0]}};
                ld = {{24{req_signed & word_sh[7]}}, word_sh[7:0]};
            end
            req_size == 2'b01: begin
                be = req_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{req_wdata[15:0]}};
                ld = {{16{req_signed & half_sel[15]}}, half_sel};
            end
            req_size == 2'b10: begin
                be = 4'b1111;
                ld = word;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wd[8*b +: 8] : word[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_cnt] <= 32'd0;
        end else if (accept & req_we & ~err) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            d1 <= 32'd0;
            e1 <= 1'b0;
        end else begin
            v1 <= accept;
            e1 <= accept & err;
            d1 <= (accept & ~req_we & ~err) ? ld : 32'd0;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (reset) begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end else begin
                    resp_valid <= v1;
                    resp_rdata <= d1;
                    resp_err   <= e1;
                end
            end
        end else begin : g_lat1
            assign resp_valid = v1;
            assign resp_rdata = d1;
            assign resp_err   = e1;
        end
    endgenerate

endmodule
